// File: rtl/seed_random_pkg.sv
// rtl/seed_random_pkg.sv - shared state encoding and LFSR defaults for the card dealer
package seed_random_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_DRAW = DRAW,
    ST_SEND = SEND
  } state_e;

  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/seed_random_lfsr.sv
// rtl/seed_random_lfsr.sv - free-running Galois LFSR, optional reload under SEED_RANDOM_RELOAD_EN
module seed_random_lfsr
  import seed_random_pkg::*;
#(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED),
  parameter int unsigned       CARD_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef SEED_RANDOM_RELOAD_EN
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              seed_ld_i,
`endif
  output logic [CARD_W-1:0] sample_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
`ifdef SEED_RANDOM_RELOAD_EN
    // A zero seed would lock the register, so it falls back to SEED
    if (seed_ld_i) begin
      lfsr_d = (seed_i == '0) ? SEED : seed_i;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign sample_o = lfsr_q[CARD_W-1:0];

endmodule

// File: rtl/seed_random_dealer.sv
// rtl/seed_random_dealer.sv - rejection-sampling card dealer with valid/ack handoff (SEED_RANDOM_RELOAD_EN adds seed reload)
module seed_random_dealer
  import seed_random_pkg::*;
#(
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED),
  parameter int unsigned       CARD_W    = 4,
  parameter int unsigned       CARD_MAX  = 13,
  parameter int unsigned       MAX_TRIES = 4,
  parameter int unsigned       CNT_W     = 8
) (
  input  logic              clk_sr_i,
  input  logic              rst_sr_i,
  input  logic              req_card_i,
  input  logic              ack_i,
`ifdef SEED_RANDOM_RELOAD_EN
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              seed_ld_i,
`endif
  output logic [CARD_W-1:0] card_o,
  output logic              valid_o,
  output logic              forced_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  deal_cnt_o
);

  localparam int unsigned       TRY_W      = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0]  LAST_TRY   = TRY_W'(MAX_TRIES - 1);
  localparam logic [CARD_W-1:0] CARD_MAX_C = CARD_W'(CARD_MAX);

  state_e             state_q, state_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [CARD_W-1:0]  card_q, card_d;
  logic               forced_q, forced_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   deal_cnt_q, deal_cnt_d;
  logic [CARD_W-1:0]  sample;

  seed_random_lfsr #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED),
    .CARD_W (CARD_W)
  ) u_lfsr (
    .clk_i     (clk_sr_i),
    .rst_ni    (rst_sr_i),
`ifdef SEED_RANDOM_RELOAD_EN
    .seed_i    (seed_i),
    .seed_ld_i (seed_ld_i),
`endif
    .sample_o  (sample)
  );

  always_comb begin
    state_d    = state_q;
    tries_d    = tries_q;
    card_d     = card_q;
    forced_d   = forced_q;
    deal_cnt_d = deal_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_card_i) begin
          state_d = ST_DRAW;
          tries_d = '0;
        end
      end
      ST_DRAW: begin
        if (sample != '0 && sample <= CARD_MAX_C) begin
          card_d   = sample;
          forced_d = 1'b0;
          state_d  = ST_SEND;
        end else if (tries_q == LAST_TRY) begin
          // Fold the out-of-range sample back into 1..CARD_MAX
          card_d   = (sample == '0) ? CARD_W'(1) : sample - CARD_MAX_C;
          forced_d = 1'b1;
          state_d  = ST_SEND;
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end
      end
      ST_SEND: begin
        if (ack_i) begin
          deal_cnt_d = deal_cnt_q + CNT_W'(1);
          tries_d    = '0;
          state_d    = req_card_i ? ST_DRAW : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clk_sr_i or negedge rst_sr_i) begin
    if (!rst_sr_i) begin
      state_q    <= ST_IDLE;
      tries_q    <= '0;
      card_q     <= '0;
      forced_q   <= 1'b0;
      valid_q    <= 1'b0;
      deal_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      card_q     <= card_d;
      forced_q   <= forced_d;
      valid_q    <= valid_d;
      deal_cnt_q <= deal_cnt_d;
    end
  end

  assign card_o     = card_q;
  assign valid_o    = valid_q;
  assign forced_o   = forced_q;
  assign state_o    = state_q;
  assign deal_cnt_o = deal_cnt_q;

endmodule

// File: tb/tb_seed_random_dealer.sv
// tb/tb_seed_random_dealer.sv - directed self-checking bench for seed_random_dealer
module tb_seed_random_dealer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        ack = 1'b0;
  logic        ack2 = 1'b0;
  logic [3:0]  card, card2;
  logic        valid, valid2, forced, forced2;
  logic [1:0]  state, state2;
  logic [7:0]  deal, deal2;
`ifdef SEED_RANDOM_RELOAD_EN
  logic [15:0] seed = 16'h0;
  logic        seed_ld = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seed_random_dealer dut (
    .clk_sr_i   (clk),
    .rst_sr_i   (rst_n),
    .req_card_i (req),
    .ack_i      (ack),
`ifdef SEED_RANDOM_RELOAD_EN
    .seed_i     (seed),
    .seed_ld_i  (seed_ld),
`endif
    .card_o     (card),
    .valid_o    (valid),
    .forced_o   (forced),
    .state_o    (state),
    .deal_cnt_o (deal)
  );

  seed_random_dealer #(.MAX_TRIES(1)) dut2 (
    .clk_sr_i   (clk),
    .rst_sr_i   (rst_n),
    .req_card_i (req),
    .ack_i      (ack2),
`ifdef SEED_RANDOM_RELOAD_EN
    .seed_i     (16'h0),
    .seed_ld_i  (1'b0),
`endif
    .card_o     (card2),
    .valid_o    (valid2),
    .forced_o   (forced2),
    .state_o    (state2),
    .deal_cnt_o (deal2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns after an edge with reset released and req asserted.
  task automatic restart();
    rst_n = 1'b0; req = 1'b0; ack = 1'b0; ack2 = 1'b0;
    tick();
    req = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    n_cmp++; if (card !== 4'd0 || forced !== 1'b0) begin n_bad++; $display("FAIL reset_card: got %0d/%0b expected 0/0", card, forced); end
    n_cmp++; if (deal !== 8'd0) begin n_bad++; $display("FAIL reset_deal: got %0d expected 0", deal); end
    n_cmp++; if (dut.u_lfsr.lfsr_q !== 16'hACE1) begin n_bad++; $display("FAIL reset_lfsr: got %h expected ace1", dut.u_lfsr.lfsr_q); end
  endtask

  task automatic test_first_draw();
    restart();
    tick();
    n_cmp++; if (dut.u_lfsr.lfsr_q !== 16'hE270) begin n_bad++; $display("FAIL e1_lfsr: got %h expected e270", dut.u_lfsr.lfsr_q); end
    n_cmp++; if (state !== 2'd1 || valid !== 1'b0) begin n_bad++; $display("FAIL e1_state: got %0d/%0b expected 1/0", state, valid); end
    tick();
    n_cmp++; if (dut.u_lfsr.lfsr_q !== 16'h7138) begin n_bad++; $display("FAIL e2_lfsr: got %h expected 7138", dut.u_lfsr.lfsr_q); end
    n_cmp++; if (state !== 2'd1 || valid !== 1'b0) begin n_bad++; $display("FAIL e2_reject: got %0d/%0b expected 1/0", state, valid); end
    tick();
    n_cmp++; if (card !== 4'd8 || valid !== 1'b1 || forced !== 1'b0) begin n_bad++; $display("FAIL e3_card: got %0d/%0b/%0b expected 8/1/0", card, valid, forced); end
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL e3_state: got %0d expected 2", state); end
  endtask

  task automatic test_hold_and_ack();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (card !== 4'd8 || valid !== 1'b1) begin n_bad++; $display("FAIL hold_%0d: got %0d/%0b expected 8/1", i, card, valid); end
    end
    ack = 1'b1; req = 1'b0;
    tick();
    ack = 1'b0;
    n_cmp++; if (deal !== 8'd1) begin n_bad++; $display("FAIL ack_deal: got %0d expected 1", deal); end
    n_cmp++; if (state !== 2'd0 || valid !== 1'b0) begin n_bad++; $display("FAIL ack_idle: got %0d/%0b expected 0/0", state, valid); end
  endtask

  task automatic test_back_to_back();
    restart();
    repeat (3) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++; if (deal !== 8'd1 || state !== 2'd1 || valid !== 1'b0) begin n_bad++; $display("FAIL b2b_e4: got %0d/%0d/%0b expected 1/1/0", deal, state, valid); end
    tick();
    n_cmp++; if (state !== 2'd1 || valid !== 1'b0) begin n_bad++; $display("FAIL b2b_e5: got %0d/%0b expected 1/0", state, valid); end
    tick();
    n_cmp++; if (card !== 4'd7 || valid !== 1'b1 || forced !== 1'b0) begin n_bad++; $display("FAIL b2b_card: got %0d/%0b/%0b expected 7/1/0", card, valid, forced); end
  endtask

  task automatic test_forced();
    restart();
    repeat (2) tick();
    n_cmp++; if (card2 !== 4'd1 || forced2 !== 1'b1 || valid2 !== 1'b1) begin n_bad++; $display("FAIL forced_zero: got %0d/%0b/%0b expected 1/1/1", card2, forced2, valid2); end
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL forced_main_draw: got %0d expected 1", state); end
    for (int e = 3; e <= 25; e++) tick();
    n_cmp++; if (card2 !== 4'd1 || valid2 !== 1'b1 || deal2 !== 8'd0) begin n_bad++; $display("FAIL forced_hold: got %0d/%0b/%0d expected 1/1/0", card2, valid2, deal2); end
    ack2 = 1'b1;
    tick();
    ack2 = 1'b0;
    n_cmp++; if (state2 !== 2'd1 || deal2 !== 8'd1) begin n_bad++; $display("FAIL forced_redraw: got %0d/%0d expected 1/1", state2, deal2); end
    tick();
    n_cmp++; if (card2 !== 4'd1 || forced2 !== 1'b1 || valid2 !== 1'b1) begin n_bad++; $display("FAIL forced_14: got %0d/%0b/%0b expected 1/1/1", card2, forced2, valid2); end
    n_cmp++; if (dut2.u_lfsr.lfsr_q !== 16'h79A7) begin n_bad++; $display("FAIL forced_lfsr: got %h expected 79a7", dut2.u_lfsr.lfsr_q); end
  endtask

  task automatic test_reset_mid();
    restart();
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (state !== 2'd0 || valid !== 1'b0 || card !== 4'd0) begin n_bad++; $display("FAIL rst_draw: got %0d/%0b/%0d expected 0/0/0", state, valid, card); end
    restart();
    repeat (3) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (2) tick();
    n_cmp++; if (valid !== 1'b1 || deal !== 8'd1) begin n_bad++; $display("FAIL rst_pre_send: got %0b/%0d expected 1/1", valid, deal); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (state !== 2'd0 || valid !== 1'b0 || card !== 4'd0 || forced !== 1'b0) begin n_bad++; $display("FAIL rst_send: got %0d/%0b/%0d/%0b expected 0/0/0/0", state, valid, card, forced); end
    n_cmp++; if (deal !== 8'd0) begin n_bad++; $display("FAIL rst_send_deal: got %0d expected 0", deal); end
  endtask

  task automatic test_wrap();
    int acks = 0;
    int gap_errs = 0;
    logic prev_valid = 1'b0;
    restart();
    ack = 1'b1;
    for (int cyc = 0; cyc < 3000 && acks < 256; cyc++) begin
      if (valid && prev_valid) gap_errs++;
      prev_valid = valid;
      if (valid) acks++;
      tick();
      if (acks == 255 && valid === 1'b0 && prev_valid) begin
        n_cmp++; if (deal !== 8'd255) begin n_bad++; $display("FAIL wrap_255: got %0d expected 255", deal); end
      end
    end
    ack = 1'b0;
    n_cmp++; if (acks != 256) begin n_bad++; $display("FAIL wrap_timeout: got %0d acks expected 256", acks); end
    n_cmp++; if (deal !== 8'd0) begin n_bad++; $display("FAIL wrap_zero: got %0d expected 0", deal); end
    n_cmp++; if (gap_errs != 0) begin n_bad++; $display("FAIL wrap_gap: got %0d back-to-back valids expected 0", gap_errs); end
  endtask

`ifdef SEED_RANDOM_RELOAD_EN
  task automatic test_reload();
    restart();
    req = 1'b0;
    seed = 16'h0E27; seed_ld = 1'b1;
    tick();
    seed_ld = 1'b0;
    n_cmp++; if (dut.u_lfsr.lfsr_q !== 16'h0E27) begin n_bad++; $display("FAIL reload_ld: got %h expected 0e27", dut.u_lfsr.lfsr_q); end
    tick();
    n_cmp++; if (dut.u_lfsr.lfsr_q !== 16'hB313) begin n_bad++; $display("FAIL reload_next: got %h expected b313", dut.u_lfsr.lfsr_q); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reload_state: got %0d expected 0", state); end
    seed = 16'h0; seed_ld = 1'b1;
    tick();
    seed_ld = 1'b0;
    n_cmp++; if (dut.u_lfsr.lfsr_q !== 16'hACE1) begin n_bad++; $display("FAIL reload_zero: got %h expected ace1", dut.u_lfsr.lfsr_q); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_draw();
    test_hold_and_ack();
    test_back_to_back();
    test_forced();
    test_reset_mid();
    test_wrap();
`ifdef SEED_RANDOM_RELOAD_EN
    test_reload();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
